// File: rtl/barret_pkg.sv
// Shared constants and pipeline entry type for the q = 3533 Barrett reducer.
package barret_pkg;

  localparam int Q        = 3533;
  localparam int MU       = 4748;
  localparam int K        = 12;
  localparam int IN_W     = 23;
  localparam int OUT_W    = 12;
  localparam int T_W      = 12;
  // Sideband tag is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [IN_W-1:0]     data;
  } pipe_entry_t;

endpackage

// File: rtl/barret_pipe_3533.sv
// Three-stage Barrett reduction of a 23-bit operand mod 3533 with an id sideband.
// All stages advance together; a low advance freezes the whole pipe.
module barret_pipe_3533
  import barret_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  input  pipe_entry_t         in_entry,
  output logic                s1_valid,
  output logic                s2_valid,
  output logic                out_valid,
  output logic [ID_MAX_W-1:0] out_id,
  output logic [OUT_W-1:0]    out_data
);

  pipe_entry_t    s1;
  pipe_entry_t    s2;
  logic [T_W-1:0] s2_t;
  logic [23:0]    prod;
  logic [23:0]    tq;
  logic [23:0]    r0;
  logic [23:0]    r1;
  logic [23:0]    r2;

  // t never exceeds floor(a/q), so a - t*q cannot underflow and stays below 3q.
  always_comb begin
    prod = 24'(s1.data >> K) * 24'(MU);
    tq   = 24'(s2_t) * 24'(Q);
    r0   = 24'(s2.data) - tq;
    r1   = (r0 >= 24'(Q)) ? r0 - 24'(Q) : r0;
    r2   = (r1 >= 24'(Q)) ? r1 - 24'(Q) : r1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      s2_t      <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else if (advance) begin
      s1        <= in_entry;
      s2        <= s1;
      s2_t      <= T_W'(prod >> K);
      out_valid <= s2.valid;
      out_id    <= s2.id;
      out_data  <= OUT_W'(r2);
    end
  end

  assign s1_valid = s1.valid;
  assign s2_valid = s2.valid;

endmodule

// File: rtl/barret_arbiter_3533.sv
// Round-robin front end sharing one Barrett mod-3533 pipeline among NUM_REQ requesters.
module barret_arbiter_3533
  import barret_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    busy
);

  logic                advance;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_found;
  int                  idx;
  pipe_entry_t         in_entry;
  logic                s1_valid;
  logic                s2_valid;
  logic [ID_MAX_W-1:0] out_id;

  assign advance = !rsp_valid || rsp_ready;

  // Scan from ptr in modular order; no grant at all while the pipe is stalled.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    req_ready = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (advance && !gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    in_entry       = '0;
    in_entry.valid = gnt_found;
    in_entry.id    = ID_MAX_W'(gnt_idx);
    in_entry.data  = req_data[gnt_idx*IN_W +: IN_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_found) begin
      ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  barret_pipe_3533 u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .in_entry (in_entry),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .out_valid(rsp_valid),
    .out_id   (out_id),
    .out_data (rsp_data)
  );

  assign rsp_id = ID_W'(out_id);
  assign busy   = s1_valid | s2_valid | rsp_valid;

endmodule

// File: tb/tb_barret_arbiter_3533.sv
// Directed and randomized checks of the shared mod-3533 reducer and its arbiter.
module tb_barret_arbiter_3533;

  localparam int NUM_REQ = 4;
  localparam int Q       = 3533;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*23-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [11:0]           rsp_data;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int id;
    int data;
  } exp_t;
  exp_t exp_q[$];

  barret_arbiter_3533 #(.NUM_REQ(NUM_REQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_data(input int i, input int v);
    req_data[i*23 +: 23] = 23'(v);
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #10;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: rsp_valid=%0b busy=%0b, expected 0 0", rsp_valid, busy);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_data !== 12'd0) begin
      failures++;
      $display("[TB] FAIL reset_data: rsp_id=%0d rsp_data=%0d, expected 0 0", rsp_id, rsp_data);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL reset_ptr: req_ready=%b, expected 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int cnt[NUM_REQ];
    int got;
    int exp_d;
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    got       = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 8) begin
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 500000*cnt[i] + 1234*i + 7);
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 8) begin
        checks++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          failures++;
          $display("[TB] FAIL rr_grant: cycle %0d req_ready=%b, expected %b", c, req_ready, 4'(1 << (c % 4)));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) cnt[i]++;
      if (rsp_valid) begin
        exp_d = (500000*(got/4) + 1234*(got%4) + 7) % Q;
        checks++;
        if (rsp_id !== 2'(got % 4) || rsp_data !== 12'(exp_d)) begin
          failures++;
          $display("[TB] FAIL rr_rsp: #%0d id=%0d data=%0d, expected id=%0d data=%0d", got, rsp_id, rsp_data, got % 4, exp_d);
        end
        got++;
      end
    end
    checks++;
    if (got != 8) begin
      failures++;
      $display("[TB] FAIL rr_count: responses=%0d, expected 8", got);
    end
  endtask

  task automatic test_single();
    int  lat;
    bit  found;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001;
    set_data(0, 1000000);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL single_grant: req_ready=%b, expected 0001", req_ready);
    end
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 10) begin
      @(negedge clk);
      req_valid = '0;
      lat++;
      #1;
      if (rsp_valid) found = 1'b1;
    end
    checks++;
    if (!found || lat != 3) begin
      failures++;
      $display("[TB] FAIL single_latency: found=%0b latency=%0d, expected 1 3", found, lat);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_data !== 12'd161) begin
      failures++;
      $display("[TB] FAIL single_data: id=%0d data=%0d, expected 0 161", rsp_id, rsp_data);
    end
  endtask

  task automatic test_boundary();
    int ops [5] = '{0, 3532, 3533, 7066, 8388607};
    int exps[5] = '{0, 3532, 0, 0, 1265};
    int got;
    got       = 0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 5) begin
        req_valid = 4'b0100;
        set_data(2, ops[c]);
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 5) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          failures++;
          $display("[TB] FAIL bnd_grant: cycle %0d req_ready=%b, expected 0100", c, req_ready);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (got >= 5) begin
          failures++;
          $display("[TB] FAIL bnd_extra: unexpected response id=%0d data=%0d", rsp_id, rsp_data);
        end else if (rsp_id !== 2'd2 || rsp_data !== 12'(exps[got])) begin
          failures++;
          $display("[TB] FAIL bnd_data: op=%0d id=%0d data=%0d, expected 2 %0d", ops[got], rsp_id, rsp_data, exps[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("[TB] FAIL bnd_count: responses=%0d, expected 5", got);
    end
  endtask

  task automatic test_stall();
    int ops[4] = '{1111111, 2222222, 3333333, 4444444};
    int k;
    int got;
    k   = 0;
    got = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      rsp_ready = (c >= 8);
      if (k < 4) begin
        req_valid = 4'b0010;
        set_data(1, ops[k]);
      end else begin
        req_valid = '0;
      end
      #1;
      if (c >= 3 && c < 8) begin
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stall_hold: cycle %0d req_ready=%b busy=%0b, expected 0000 1", c, req_ready, busy);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 12'(ops[0] % Q)) begin
          failures++;
          $display("[TB] FAIL stall_out: cycle %0d valid=%0b id=%0d data=%0d, expected 1 1 %0d", c, rsp_valid, rsp_id, rsp_data, ops[0] % Q);
        end
      end
      if (req_ready[1]) k++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (got >= 4 || rsp_id !== 2'd1 || rsp_data !== 12'(ops[got % 4] % Q)) begin
          failures++;
          $display("[TB] FAIL stall_rsp: #%0d id=%0d data=%0d, expected 1 %0d", got, rsp_id, rsp_data, ops[got % 4] % Q);
        end
        got++;
      end
    end
    checks++;
    if (got != 4 || k != 4) begin
      failures++;
      $display("[TB] FAIL stall_count: sent=%0d responses=%0d, expected 4 4", k, got);
    end
  endtask

  task automatic test_reset_mid();
    bit stale;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b0010;
      set_data(1, 100000 + c);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_inflight: rsp_valid=%0b busy=%0b, expected 1 1", rsp_valid, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 12'd0) begin
      failures++;
      $display("[TB] FAIL mid_clear: valid=%0b busy=%0b id=%0d data=%0d, expected all 0", rsp_valid, busy, rsp_id, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || busy) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_stale: activity seen after reset, expected none");
    end
    @(negedge clk);
    req_valid = 4'b1010;
    set_data(1, 77777);
    set_data(3, 88888);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL mid_first_grant: req_ready=%b, expected 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] hold_v;
    int   hold_d[NUM_REQ];
    int   planned;
    int   cyc;
    exp_t e;
    hold_v  = '0;
    planned = 0;
    cyc     = 0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) hold_d[i] = 0;
    while ((planned < 10000 || hold_v != '0 || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hold_v[i] && planned < 10000 && $urandom_range(0, 1) == 1) begin
          hold_v[i] = 1'b1;
          if ($urandom_range(0, 7) == 0) hold_d[i] = 8388607 - int'($urandom_range(0, 10));
          else hold_d[i] = int'($urandom_range(0, 8388607));
          set_data(i, hold_d[i]);
          planned++;
        end
      end
      req_valid = hold_v;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ((req_ready & ~req_valid) != '0 || !$onehot0(req_ready)) begin
        failures++;
        $display("[TB] FAIL rand_grant: req_ready=%b req_valid=%b, expected one-hot subset", req_ready, req_valid);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && hold_v[i]) begin
          exp_q.push_back('{id: i, data: hold_d[i] % Q});
          hold_v[i] = 1'b0;
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_extra: unexpected id=%0d data=%0d", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          if (rsp_id !== 2'(e.id) || rsp_data !== 12'(e.data)) begin
            failures++;
            $display("[TB] FAIL rand_rsp: id=%0d data=%0d, expected id=%0d data=%0d", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
    checks++;
    if (cyc >= 60000 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_drain: cycles=%0d pending=%0d, expected drain with 0 pending", cyc, exp_q.size());
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_boundary();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
